// File: rtl/uart_program_loader_if.sv
// Bundle of the loader's stream, memory-write and core-control signals.
// The loader side uses modport master; the UART/memory/core side uses slave.
interface uart_program_loader_if #(
  parameter int unsigned IMEM_ADDR_WIDTH = 10
);
  logic                       rx_valid;
  logic [7:0]                 rx_data;
  logic                       rx_error;
  logic                       load_req;
  logic                       imem_we;
  logic [IMEM_ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]                imem_wdata;
  logic                       cpu_hold;
  logic                       cpu_start;
  logic                       load_error;
  logic [IMEM_ADDR_WIDTH:0]   words_loaded;

  modport master (
    input  rx_valid, rx_data, rx_error, load_req,
    output imem_we, imem_addr, imem_wdata, cpu_hold, cpu_start, load_error, words_loaded
  );

  modport slave (
    output rx_valid, rx_data, rx_error, load_req,
    input  imem_we, imem_addr, imem_wdata, cpu_hold, cpu_start, load_error, words_loaded
  );
endinterface

// File: rtl/uart_program_loader.sv
// Boot loader: receives a little-endian word count followed by that many
// little-endian words over the UART byte stream, writes them to instruction
// memory from address 0 upward, then releases the core.
module uart_program_loader #(
  parameter int unsigned IMEM_ADDR_WIDTH = 10
) (
  input logic                  clk,
  input logic                  rst,
  uart_program_loader_if.master bus
);

  localparam int unsigned AW = IMEM_ADDR_WIDTH;

  typedef enum logic [1:0] {StLen, StLoad, StRun, StErr} state_e;

  state_e       state_q;
  logic [1:0]   byte_cnt_q;
  logic [23:0]  word_q;      // bytes 0..2 of the word being assembled
  logic [AW:0]  n_q;
  logic [AW:0]  words_q;
  logic         we_q;
  logic [AW-1:0] addr_q;
  logic [31:0]  wdata_q;
  logic         hold_q;
  logic         start_q;
  logic         err_q;

  logic [31:0]  full_word;
  logic [32:0]  capacity;

  assign full_word = {bus.rx_data, word_q};
  assign capacity  = 33'(1) << AW;

  // Single FSM with registered outputs; priority is rst > load_req > rx_error > rx_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StLen;
      byte_cnt_q <= '0;
      word_q     <= '0;
      n_q        <= '0;
      words_q    <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      hold_q     <= 1'b1;
      start_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      we_q    <= 1'b0;
      start_q <= 1'b0;
      if (bus.load_req) begin
        // Restart discards any partial word; a write already on the port completes.
        state_q    <= StLen;
        hold_q     <= 1'b1;
        byte_cnt_q <= '0;
        word_q     <= '0;
        n_q        <= '0;
        words_q    <= '0;
        err_q      <= 1'b0;
      end else begin
        unique case (state_q)
          StLen, StLoad: begin
            if (bus.rx_error) begin
              state_q <= StErr;
              hold_q  <= 1'b1;
              err_q   <= 1'b1;
            end else if (state_q == StLoad && words_q == n_q) begin
              // Last word was written in the previous cycle.
              state_q <= StRun;
              hold_q  <= 1'b0;
              start_q <= 1'b1;
            end else if (bus.rx_valid) begin
              byte_cnt_q <= byte_cnt_q + 2'd1;
              case (byte_cnt_q)
                2'd0:    word_q[7:0]   <= bus.rx_data;
                2'd1:    word_q[15:8]  <= bus.rx_data;
                2'd2:    word_q[23:16] <= bus.rx_data;
                default: word_q        <= '0;
              endcase
              if (byte_cnt_q == 2'd3) begin
                if (state_q == StLen) begin
                  if (full_word == '0) begin
                    state_q <= StRun;
                    hold_q  <= 1'b0;
                    start_q <= 1'b1;
                  end else if ({1'b0, full_word} > capacity) begin
                    state_q <= StErr;
                    err_q   <= 1'b1;
                  end else begin
                    state_q <= StLoad;
                    n_q     <= full_word[AW:0];
                  end
                end else begin
                  we_q    <= 1'b1;
                  addr_q  <= words_q[AW-1:0];
                  wdata_q <= full_word;
                  words_q <= words_q + (AW + 1)'(1);
                end
              end
            end
          end
          StRun, StErr: begin
            // Bytes and framing errors are ignored until load_req.
          end
        endcase
      end
    end
  end

  assign bus.imem_we      = we_q;
  assign bus.imem_addr    = addr_q;
  assign bus.imem_wdata   = wdata_q;
  assign bus.cpu_hold     = hold_q;
  assign bus.cpu_start    = start_q;
  assign bus.load_error   = err_q;
  assign bus.words_loaded = words_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Bench for uart_program_loader: directed protocol scenarios plus randomized
// loads compared against an address->word model built from the byte protocol.
module tb_uart_program_loader;

  localparam int unsigned AW = 4;
  localparam int unsigned CAP = 1 << AW;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  uart_program_loader_if #(.IMEM_ADDR_WIDTH(AW)) bus ();

  uart_program_loader #(.IMEM_ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int  checks   = 0;
  int  failures = 0;
  wr_t got_q[$];
  int  starts = 0;

  // Observed write log and start-pulse count, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.imem_we) got_q.push_back('{addr: bus.imem_addr, data: bus.imem_wdata});
    if (bus.cpu_start) starts++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge; returns at the negedge right after the byte was taken.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  // Little-endian word; no gap after the last byte so latency can be checked.
  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int i = 0; i < 4; i++)
      send_byte(w[8*i +: 8], (i == 3) ? 0 : $urandom_range(0, max_gap));
  endtask

  task automatic pulse_load_req();
    bus.load_req = 1'b1;
    @(negedge clk);
    bus.load_req = 1'b0;
  endtask

  int          base;
  int          n;
  int          st0;
  logic [31:0] w0;
  logic [31:0] words [CAP];
  wr_t         exp_q[$];

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_error = 1'b0;
    bus.load_req = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_hold",  64'(bus.cpu_hold), 64'(1));
    check("rst_start", 64'(bus.cpu_start), 64'(0));
    check("rst_we",    64'(bus.imem_we), 64'(0));
    check("rst_addr",  64'(bus.imem_addr), 64'(0));
    check("rst_wdata", 64'(bus.imem_wdata), 64'(0));
    check("rst_err",   64'(bus.load_error), 64'(0));
    check("rst_words", 64'(bus.words_loaded), 64'(0));

    // Basic two-word load
    st0 = starts;
    send_word(32'd2, 1);
    send_word(32'h0010_0513, 2);
    check("basic_we0",    64'(bus.imem_we), 64'(1));
    check("basic_addr0",  64'(bus.imem_addr), 64'(0));
    check("basic_data0",  64'(bus.imem_wdata), 64'h0010_0513);
    check("basic_hold_l", 64'(bus.cpu_hold), 64'(1));
    send_word(32'h0000_006F, 0);
    check("basic_we1",    64'(bus.imem_we), 64'(1));
    check("basic_addr1",  64'(bus.imem_addr), 64'(1));
    check("basic_data1",  64'(bus.imem_wdata), 64'h0000_006F);
    @(negedge clk);
    check("basic_start",  64'(bus.cpu_start), 64'(1));
    check("basic_hold",   64'(bus.cpu_hold), 64'(0));
    check("basic_we_off", 64'(bus.imem_we), 64'(0));
    check("basic_words",  64'(bus.words_loaded), 64'(2));
    @(negedge clk);
    check("basic_start_1cyc", 64'(bus.cpu_start), 64'(0));
    check("basic_nstarts",    64'(starts - st0), 64'(1));

    // Bytes and errors in RUN are ignored
    base = got_q.size();
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), $urandom_range(0, 1));
    bus.rx_error = 1'b1;
    @(negedge clk);
    bus.rx_error = 1'b0;
    check("run_nowrite", 64'(got_q.size() - base), 64'(0));
    check("run_hold",    64'(bus.cpu_hold), 64'(0));
    check("run_err",     64'(bus.load_error), 64'(0));

    // Reload from RUN
    pulse_load_req();
    check("reload_hold",  64'(bus.cpu_hold), 64'(1));
    check("reload_words", 64'(bus.words_loaded), 64'(0));

    // Zero length
    base = got_q.size();
    send_word(32'd0, 2);
    check("zero_start",   64'(bus.cpu_start), 64'(1));
    check("zero_hold",    64'(bus.cpu_hold), 64'(0));
    check("zero_nowrite", 64'(got_q.size() - base), 64'(0));
    pulse_load_req();

    // Oversize: directed N = CAP+1, then a random oversize count
    for (int t = 0; t < 2; t++) begin
      n = (t == 0) ? CAP + 1 : int'($urandom_range(CAP + 1, 32'h7fff_ffff));
      base = got_q.size();
      send_word(32'(n), 1);
      @(negedge clk);
      check("over_err",  64'(bus.load_error), 64'(1));
      check("over_hold", 64'(bus.cpu_hold), 64'(1));
      for (int i = 0; i < 8; i++) send_byte(8'($urandom), 0);
      check("over_nowrite", 64'(got_q.size() - base), 64'(0));
      pulse_load_req();
      check("over_clear", 64'(bus.load_error), 64'(0));
    end

    // Abort mid-word, load_req coinciding with a byte
    base = got_q.size();
    send_word(32'd1, 1);
    send_byte(8'h11, 1);
    send_byte(8'h22, 0);
    bus.load_req = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h33;
    @(negedge clk);
    bus.load_req = 1'b0;
    bus.rx_valid = 1'b0;
    check("abort_we",    64'(bus.imem_we), 64'(0));
    check("abort_hold",  64'(bus.cpu_hold), 64'(1));
    check("abort_words", 64'(bus.words_loaded), 64'(0));
    send_byte(8'h44, 2);
    check("abort_nowrite", 64'(got_q.size() - base), 64'(0));
    pulse_load_req();
    send_word(32'd1, 1);
    send_word(32'hDEAD_BEEF, 1);
    check("fresh_we",   64'(bus.imem_we), 64'(1));
    check("fresh_addr", 64'(bus.imem_addr), 64'(0));
    check("fresh_data", 64'(bus.imem_wdata), 64'hDEAD_BEEF);
    @(negedge clk);
    check("fresh_start", 64'(bus.cpu_start), 64'(1));

    // Framing error after one word
    pulse_load_req();
    base = got_q.size();
    w0 = $urandom;
    send_word(32'd3, 1);
    send_word(w0, 1);
    send_byte(8'h5A, 0);
    bus.rx_error = 1'b1;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_error = 1'b0;
    bus.rx_valid = 1'b0;
    check("ferr_err",    64'(bus.load_error), 64'(1));
    check("ferr_hold",   64'(bus.cpu_hold), 64'(1));
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), 0);
    check("ferr_nwrites", 64'(got_q.size() - base), 64'(1));
    if (got_q.size() > base) begin
      check("ferr_addr", 64'(got_q[base].addr), 64'(0));
      check("ferr_data", 64'(got_q[base].data), 64'(w0));
    end
    pulse_load_req();
    check("ferr_clear", 64'(bus.load_error), 64'(0));

    // rst mid-load returns to the reset state
    send_word(32'd2, 0);
    send_word(32'($urandom), 0);
    send_byte(8'h77, 0);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_we",    64'(bus.imem_we), 64'(0));
    check("mrst_addr",  64'(bus.imem_addr), 64'(0));
    check("mrst_wdata", 64'(bus.imem_wdata), 64'(0));
    check("mrst_words", 64'(bus.words_loaded), 64'(0));
    check("mrst_hold",  64'(bus.cpu_hold), 64'(1));
    rst = 1'b0;

    // Randomized loads; the first is the maximum-size image
    for (int it = 0; it < 4; it++) begin
      n = (it == 0) ? CAP : int'($urandom_range(1, CAP));
      exp_q.delete();
      for (int k = 0; k < n; k++) begin
        words[k] = $urandom;
        exp_q.push_back('{addr: AW'(k), data: words[k]});
      end
      base = got_q.size();
      st0  = starts;
      send_word(32'(n), 2);
      for (int k = 0; k < n; k++) send_word(words[k], 2);
      @(negedge clk);
      check("rand_start", 64'(bus.cpu_start), 64'(1));
      check("rand_hold",  64'(bus.cpu_hold), 64'(0));
      check("rand_words", 64'(bus.words_loaded), 64'(n));
      check("rand_count", 64'(got_q.size() - base), 64'(n));
      for (int k = 0; k < n && base + k < got_q.size(); k++) begin
        check("rand_addr", 64'(got_q[base + k].addr), 64'(exp_q[k].addr));
        check("rand_data", 64'(got_q[base + k].data), 64'(exp_q[k].data));
      end
      @(negedge clk);
      check("rand_nstarts", 64'(starts - st0), 64'(1));
      pulse_load_req();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
